// File: rtl/sda_kernel_ctrl_reg_multi_if.sv
// Register-bus and per-channel go/done handshake bundle between the AXI
// register selector (master side) and the kernel control block (slave side).
`timescale 1ns/1ps
interface sda_kernel_ctrl_reg_multi_if #(
  parameter int NUM_CHANNELS   = 4,
  parameter int REG_ADDR_WIDTH = 8
);
  logic                      reg_req;
  logic                      reg_ack;
  logic                      reg_write_en;
  logic [REG_ADDR_WIDTH-1:0] reg_addr;
  logic [31:0]               reg_wdata;
  logic [31:0]               reg_rdata;
  logic [NUM_CHANNELS-1:0]   go_r;
  logic [NUM_CHANNELS-1:0]   go_a;
  logic [NUM_CHANNELS-1:0]   done_r;
  logic [NUM_CHANNELS-1:0]   done_a;
  logic                      interrupt;

  modport master (
    output reg_req, reg_write_en, reg_addr, reg_wdata, go_a, done_r,
    input  reg_ack, reg_rdata, go_r, done_a, interrupt
  );

  modport slave (
    input  reg_req, reg_write_en, reg_addr, reg_wdata, go_a, done_r,
    output reg_ack, reg_rdata, go_r, done_a, interrupt
  );
endinterface

// File: rtl/sda_kernel_ctrl_reg_multi.sv
// ap_ctrl register block launching NUM_CHANNELS action cores over four-phase
// go/done handshakes, with auto-restart, interrupt registers and a run-cycle counter.
`timescale 1ns/1ps
module sda_kernel_ctrl_reg_multi #(
  parameter int NUM_CHANNELS      = 4,
  parameter int REG_ADDR_WIDTH    = 8,
  parameter int CYCLE_COUNT_WIDTH = 32
) (
  input logic                         clk,
  input logic                         reset,
  sda_kernel_ctrl_reg_multi_if.slave  bus
);

  typedef enum logic [2:0] {
    CH_IDLE, CH_GO_HI, CH_GO_LO, CH_RUN, CH_DN_HI, CH_DN_LO, CH_FIN
  } ch_state_t;

  localparam logic [REG_ADDR_WIDTH-1:0] ADDR_CTRL   = REG_ADDR_WIDTH'(8'h00);
  localparam logic [REG_ADDR_WIDTH-1:0] ADDR_GIE    = REG_ADDR_WIDTH'(8'h04);
  localparam logic [REG_ADDR_WIDTH-1:0] ADDR_IER    = REG_ADDR_WIDTH'(8'h08);
  localparam logic [REG_ADDR_WIDTH-1:0] ADDR_ISR    = REG_ADDR_WIDTH'(8'h0C);
  localparam logic [REG_ADDR_WIDTH-1:0] ADDR_CYCLES = REG_ADDR_WIDTH'(8'h10);
  localparam logic [REG_ADDR_WIDTH-1:0] ADDR_BUSY   = REG_ADDR_WIDTH'(8'h14);

  ch_state_t state_q [NUM_CHANNELS];
  ch_state_t state_d [NUM_CHANNELS];

  logic                         ack_q;
  logic [31:0]                  rdata_q;
  logic [31:0]                  rdata_d;
  logic                         ap_start, ap_done, ap_idle, ap_ready, auto_restart;
  logic                         gie;
  logic [1:0]                   ier, isr, isr_next;
  logic                         irq_q;
  logic                         running;
  logic [CYCLE_COUNT_WIDTH-1:0] cycles;
  logic [NUM_CHANNELS-1:0]      busy, go_vec, done_vec;

  logic access, wr, rd;
  logic launch, all_passed, all_fin, ready_evt, complete;

  assign access = bus.reg_req & ~ack_q;
  assign wr     = access &  bus.reg_write_en;
  assign rd     = access & ~bus.reg_write_en;

  // running tracks an in-flight iteration; ap_idle stays low across the
  // one-cycle gap between an auto-restart completion and the next launch.
  assign launch    = ap_start & ~running;
  assign ready_evt = running & ap_start & all_passed;
  assign complete  = running & all_fin;

  always_comb begin
    all_passed = 1'b1;
    all_fin    = 1'b1;
    busy       = '0;
    go_vec     = '0;
    done_vec   = '0;
    for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
      state_d[c] = state_q[c];
      unique case (state_q[c])
        CH_IDLE:  if (launch)          state_d[c] = CH_GO_HI;
        CH_GO_HI: if (bus.go_a[c])     state_d[c] = CH_GO_LO;
        CH_GO_LO: if (!bus.go_a[c])    state_d[c] = CH_RUN;
        CH_RUN:   if (bus.done_r[c])   state_d[c] = CH_DN_HI;
        CH_DN_HI: if (!bus.done_r[c])  state_d[c] = CH_DN_LO;
        CH_DN_LO:                      state_d[c] = CH_FIN;
        CH_FIN:   if (complete)        state_d[c] = CH_IDLE;
        default:                       state_d[c] = CH_IDLE;
      endcase
      if (state_q[c] inside {CH_IDLE, CH_GO_HI, CH_GO_LO}) all_passed = 1'b0;
      if (state_q[c] != CH_FIN) all_fin = 1'b0;
      busy[c]     = (state_q[c] != CH_IDLE);
      go_vec[c]   = (state_q[c] == CH_GO_HI);
      done_vec[c] = (state_q[c] == CH_DN_HI);
    end
  end

  always_comb begin
    rdata_d = '0;
    unique case (bus.reg_addr)
      ADDR_CTRL:   rdata_d = {24'b0, auto_restart, 3'b0, ap_ready, ap_idle, ap_done, ap_start};
      ADDR_GIE:    rdata_d = {31'b0, gie};
      ADDR_IER:    rdata_d = {30'b0, ier};
      ADDR_ISR:    rdata_d = {30'b0, isr};
      ADDR_CYCLES: rdata_d[CYCLE_COUNT_WIDTH-1:0] = cycles;
      ADDR_BUSY:   rdata_d[NUM_CHANNELS-1:0] = busy;
      default:     rdata_d = '0;
    endcase
  end

  // Event sets are applied after the host toggle so a same-cycle event wins.
  always_comb begin
    isr_next = isr;
    if (wr && bus.reg_addr == ADDR_ISR) isr_next = isr ^ bus.reg_wdata[1:0];
    if (complete)  isr_next[0] = 1'b1;
    if (ready_evt) isr_next[1] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned c = 0; c < NUM_CHANNELS; c++) state_q[c] <= CH_IDLE;
    end else begin
      for (int unsigned c = 0; c < NUM_CHANNELS; c++) state_q[c] <= state_d[c];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ack_q        <= 1'b0;
      rdata_q      <= '0;
      ap_start     <= 1'b0;
      ap_done      <= 1'b0;
      ap_idle      <= 1'b1;
      ap_ready     <= 1'b0;
      auto_restart <= 1'b0;
      gie          <= 1'b0;
      ier          <= '0;
      isr          <= '0;
      irq_q        <= 1'b0;
      running      <= 1'b0;
      cycles       <= '0;
    end else begin
      ack_q <= access;
      if (rd) rdata_q <= rdata_d;

      if (complete && auto_restart)
        ap_start <= 1'b1;
      else if (ready_evt)
        ap_start <= 1'b0;
      else if (wr && bus.reg_addr == ADDR_CTRL && bus.reg_wdata[0] && ap_idle)
        ap_start <= 1'b1;

      if (complete)
        ap_done <= 1'b1;
      else if (rd && bus.reg_addr == ADDR_CTRL)
        ap_done <= 1'b0;

      if (launch)
        ap_idle <= 1'b0;
      else if (complete && !auto_restart)
        ap_idle <= 1'b1;

      ap_ready <= ready_evt;
      if (wr && bus.reg_addr == ADDR_CTRL) auto_restart <= bus.reg_wdata[7];
      if (wr && bus.reg_addr == ADDR_GIE)  gie <= bus.reg_wdata[0];
      if (wr && bus.reg_addr == ADDR_IER)  ier <= bus.reg_wdata[1:0];
      isr   <= isr_next;
      irq_q <= gie & |(ier & isr);

      if (launch)
        running <= 1'b1;
      else if (complete)
        running <= 1'b0;

      if (launch)
        cycles <= '0;
      else if (running && !complete && !(&cycles))
        cycles <= cycles + CYCLE_COUNT_WIDTH'(1);
    end
  end

  assign bus.reg_ack   = ack_q;
  assign bus.reg_rdata = rdata_q;
  assign bus.go_r      = go_vec;
  assign bus.done_a    = done_vec;
  assign bus.interrupt = irq_q;

endmodule

// File: tb/tb_sda_kernel_ctrl_reg_multi.sv
// Scoreboarded bench: register reads are predicted from a register-level model,
// the channel responders emulate action cores and check handshake timing.
`timescale 1ns/1ps
module tb_sda_kernel_ctrl_reg_multi;
  localparam int NC = 4;
  localparam int AW = 8;
  localparam logic [31:0] ALL_CH = (32'd1 << NC) - 1;
  localparam logic [7:0] A_CTRL = 8'h00, A_GIE = 8'h04, A_IER = 8'h08,
                         A_ISR = 8'h0C, A_CYC = 8'h10, A_BUSY = 8'h14;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sda_kernel_ctrl_reg_multi_if #(.NUM_CHANNELS(NC), .REG_ADDR_WIDTH(AW)) bus ();

  sda_kernel_ctrl_reg_multi #(
    .NUM_CHANNELS(NC), .REG_ADDR_WIDTH(AW), .CYCLE_COUNT_WIDTH(32)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // scoreboard of issued register accesses
  typedef struct { bit is_read; logic [31:0] exp; string name; } txn_t;
  txn_t sbq[$];

  always @(negedge clk) begin
    if (bus.reg_ack === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_ack: got ack with no access outstanding (cycle %0d)", cyc);
      end else begin
        txn_t t;
        t = sbq.pop_front();
        if (t.is_read) check(t.name, bus.reg_rdata, t.exp);
      end
    end
  end

  task automatic reg_access(input bit we, input logic [7:0] addr, input logic [31:0] wdata,
                            input logic [31:0] exp, input string name);
    txn_t t;
    int n;
    t.is_read = !we; t.exp = exp; t.name = name;
    sbq.push_back(t);
    @(negedge clk);
    bus.reg_req = 1'b1; bus.reg_write_en = we; bus.reg_addr = addr; bus.reg_wdata = wdata;
    n = 0;
    do begin @(negedge clk); n++; end while (bus.reg_ack !== 1'b1 && n < 20);
    check({name, "_ack"}, bus.reg_ack, 1'b1);
    bus.reg_req = 1'b0;
  endtask

  task automatic reg_write(input logic [7:0] addr, input logic [31:0] data);
    reg_access(1'b1, addr, data, '0, "wr");
  endtask

  task automatic reg_read(input logic [7:0] addr, input logic [31:0] exp, input string name);
    reg_access(1'b0, addr, '0, exp, name);
  endtask

  // action-core responders
  int  rs[NC], gcnt[NC], go_dly[NC], done_rel[NC], rises[NC];
  bit  early[NC];
  int  launch_cyc = 0, last_drop_cyc = 0, last_drop_ch = -1, drops = 0, runs_done = 0;
  int  exp_launch = -1;
  bit  auto_mode = 1'b0;

  initial begin
    for (int c = 0; c < NC; c++) begin
      rs[c] = 0; rises[c] = 0; go_dly[c] = 1; done_rel[c] = 10; early[c] = 1'b0;
    end
    bus.go_a = '0; bus.done_r = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        for (int c = 0; c < NC; c++) rs[c] = 0;
        bus.go_a = '0; bus.done_r = '0; drops = 0; exp_launch = -1;
      end else begin
        for (int c = 0; c < NC; c++) begin
          case (rs[c])
            0: if (bus.go_r[c]) begin
                 rises[c]++;
                 if (c == 0) begin
                   launch_cyc = cyc;
                   check("go_r_all_launch", 32'(bus.go_r), ALL_CH);
                   if (exp_launch >= 0) begin
                     check("auto_relaunch_cycle", launch_cyc, exp_launch);
                     exp_launch = -1;
                   end
                 end
                 gcnt[c] = go_dly[c];
                 if (early[c]) bus.done_r[c] = 1'b1;
                 rs[c] = 1;
               end
            1: begin
                 if (early[c]) check("done_a_held_off", 32'(bus.done_a[c]), 0);
                 if (gcnt[c] == 0) begin bus.go_a[c] = 1'b1; rs[c] = 2; end
                 else gcnt[c]--;
               end
            2: begin
                 if (early[c]) check("done_a_held_off", 32'(bus.done_a[c]), 0);
                 if (!bus.go_r[c]) begin bus.go_a[c] = 1'b0; rs[c] = 3; end
               end
            3: if (cyc - launch_cyc >= done_rel[c]) begin bus.done_r[c] = 1'b1; rs[c] = 4; end
            4: if (bus.done_a[c]) begin
                 bus.done_r[c] = 1'b0;
                 rs[c] = 0;
                 drops++;
                 if (drops == NC) begin
                   drops = 0; last_drop_cyc = cyc; last_drop_ch = c; runs_done++;
                   exp_launch = auto_mode ? cyc + 4 : -1;
                 end
               end
            default: rs[c] = 0;
          endcase
        end
      end
    end
  end

  // register-level reference model
  bit       m_auto, m_gie;
  bit [1:0] m_ier, m_isr;

  function automatic logic [31:0] ctrl_exp(input bit done, input bit idle);
    return {24'b0, m_auto, 3'b0, 1'b0, idle, done, 1'b0};
  endfunction
  function automatic logic [31:0] irq_exp();
    return {31'b0, m_gie & |(m_ier & m_isr)};
  endfunction
  // CYCLES counts edges strictly between the launch edge and the completion
  // edge, which falls three edges after the last done_r release.
  function automatic logic [31:0] cycles_exp();
    return 32'(last_drop_cyc - launch_cyc + 2);
  endfunction

  task automatic wait_runs(input int target);
    int n = 0;
    while (runs_done < target && n < 3000) begin @(posedge clk); n++; end
    check("run_complete", 32'(runs_done >= target), 1);
  endtask

  task automatic post_run_checks(input string tag);
    repeat (6) @(negedge clk);
    m_isr = 2'b11;
    reg_read(A_CTRL, ctrl_exp(1, 1), {tag, "_ctrl_done"});
    reg_read(A_CTRL, ctrl_exp(0, 1), {tag, "_ctrl_cleared"});
    reg_read(A_CYC,  cycles_exp(),   {tag, "_cycles"});
    reg_read(A_ISR,  32'(m_isr),     {tag, "_isr"});
    reg_read(A_BUSY, 0,              {tag, "_chan_busy"});
    check({tag, "_interrupt"}, 32'(bus.interrupt), irq_exp());
  endtask

  initial begin
    int base, d, n;
    int base_r[NC];
    logic [31:0] v;
    bus.reg_req = 1'b0; bus.reg_write_en = 1'b0; bus.reg_addr = '0; bus.reg_wdata = '0;
    m_auto = 0; m_gie = 0; m_ier = 0; m_isr = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // reset state and address decode
    check("reset_go_r", 32'(bus.go_r), 0);
    check("reset_done_a", 32'(bus.done_a), 0);
    check("reset_interrupt", 32'(bus.interrupt), 0);
    reg_read(A_CTRL, 32'h4, "reset_ctrl");
    reg_read(A_CYC, 0, "reset_cycles");
    reg_read(A_ISR, 0, "reset_isr");
    reg_read(8'h20, 0, "unmapped_read");
    reg_write(8'h24, 32'hFFFF_FFFF);
    reg_write(A_CYC, 32'h1234);
    reg_read(A_GIE, 0, "gie_after_unmapped_wr");
    reg_read(A_CYC, 0, "cycles_read_only");

    // scripted completion order 3,0,2,1
    for (int c = 0; c < NC; c++) go_dly[c] = 1;
    done_rel[0] = 12; done_rel[1] = 20; done_rel[2] = 15; done_rel[3] = 10;
    base = runs_done;
    reg_write(A_CTRL, 32'h1);
    wait_runs(base + 1);
    check("last_done_channel", last_drop_ch, 1);
    post_run_checks("ordered");

    // interrupt timing and ISR toggle
    reg_write(A_ISR, 32'h3); m_isr = 0;
    reg_write(A_GIE, 32'h1); m_gie = 1;
    reg_write(A_IER, 32'h1); m_ier = 2'b01;
    base = runs_done;
    reg_write(A_CTRL, 32'h1);
    wait_runs(base + 1);
    d = last_drop_cyc;
    n = 0;
    while (cyc < d + 3 && n < 20) begin @(negedge clk); n++; end
    check("irq_before_done", 32'(bus.interrupt), 0);
    @(negedge clk);
    check("irq_after_done", 32'(bus.interrupt), 1);
    post_run_checks("irq_run");
    reg_write(A_ISR, 32'h1); m_isr ^= 2'b01;
    @(negedge clk);
    check("irq_isr_toggle_clear", 32'(bus.interrupt), irq_exp());
    reg_write(A_ISR, 32'h1); m_isr ^= 2'b01;
    @(negedge clk);
    check("irq_isr_toggle_set", 32'(bus.interrupt), irq_exp());

    // auto-restart: three back-to-back iterations, stop requested in the third
    for (int c = 0; c < NC; c++) begin go_dly[c] = 1; done_rel[c] = 8 + c; base_r[c] = rises[c]; end
    base = runs_done;
    auto_mode = 1; m_auto = 1;
    reg_write(A_CTRL, 32'h81);
    n = 0;
    while (rises[0] < base_r[0] + 3 && n < 2000) begin @(posedge clk); n++; end
    auto_mode = 0; m_auto = 0;
    reg_write(A_CTRL, 32'h0);
    wait_runs(base + 3);
    repeat (10) @(negedge clk);
    for (int c = 0; c < NC; c++) check("auto_launch_count", rises[c] - base_r[c], 3);
    post_run_checks("auto_stop");

    // start while busy is ignored; early done_r is held off until RUN
    for (int c = 0; c < NC; c++) begin go_dly[c] = 1; done_rel[c] = 25; base_r[c] = rises[c]; end
    go_dly[2] = 5; early[2] = 1'b1; done_rel[2] = 0;
    base = runs_done;
    reg_write(A_CTRL, 32'h1);
    n = 0;
    while (rises[0] == base_r[0] && n < 100) begin @(posedge clk); n++; end
    reg_write(A_CTRL, 32'h1);
    wait_runs(base + 1);
    repeat (10) @(negedge clk);
    early[2] = 1'b0;
    for (int c = 0; c < NC; c++) check("busy_start_ignored", rises[c] - base_r[c], 1);
    post_run_checks("busy_start");

    // reset while all channels are in RUN
    for (int c = 0; c < NC; c++) begin go_dly[c] = 1; done_rel[c] = 500; end
    reg_write(A_CTRL, 32'h1);
    n = 0;
    while (!(rs[0] == 3 && rs[1] == 3 && rs[2] == 3 && rs[3] == 3) && n < 100) begin
      @(posedge clk); n++;
    end
    repeat (3) @(negedge clk);
    reg_read(A_BUSY, ALL_CH, "chan_busy_running");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrun_reset_go_r", 32'(bus.go_r), 0);
    check("midrun_reset_done_a", 32'(bus.done_a), 0);
    reset = 1'b0;
    m_auto = 0; m_gie = 0; m_ier = 0; m_isr = 0;
    check("midrun_reset_interrupt", 32'(bus.interrupt), 0);
    reg_read(A_CTRL, 32'h4, "midrun_reset_ctrl");
    reg_read(A_CYC, 0, "midrun_reset_cycles");
    reg_read(A_BUSY, 0, "midrun_reset_busy");

    // randomized runs
    for (int it = 0; it < 8; it++) begin
      for (int c = 0; c < NC; c++) begin
        go_dly[c]   = $urandom_range(0, 3);
        done_rel[c] = $urandom_range(4, 30);
        early[c]    = ($urandom_range(0, 3) == 0);
      end
      m_gie = 1'($urandom_range(0, 1));
      m_ier = 2'($urandom_range(0, 3));
      reg_write(A_GIE, {31'b0, m_gie});
      reg_write(A_IER, {30'b0, m_ier});
      reg_read(A_IER, {30'b0, m_ier}, "rand_ier");
      base = runs_done;
      reg_write(A_CTRL, 32'h1);
      wait_runs(base + 1);
      post_run_checks("rand");
      v = 32'($urandom_range(0, 3));
      reg_write(A_ISR, v); m_isr ^= v[1:0];
      reg_read(A_ISR, {30'b0, m_isr}, "rand_isr_toggle");
      check("rand_irq_after_toggle", 32'(bus.interrupt), irq_exp());
    end
    for (int c = 0; c < NC; c++) early[c] = 1'b0;

    repeat (3) @(negedge clk);
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending accesses expected 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
